// File: rtl/multicycle_seq_if.sv
// Memory-side handshake bundle between the multi-cycle sequencer and the
// instruction/data memories.
interface multicycle_seq_if;
  logic imem_req;
  logic imem_ack;
  logic ir_en;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output ir_en,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  ir_en,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: steps each instruction through FETCH..COMMIT and
// drives the IR-load, memory-request, regfile-write and PC-write strobes.
module multicycle_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             pc_sel,
  multicycle_seq_if.master bus,
  output logic             reg_wen,
  output logic             pc_wen,
  output logic             pc_src,
  output logic             busy,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LW   = 7'h0D;
  localparam logic [6:0] OP_SW   = 7'h0E;
  localparam logic [6:0] OP_BRLO = 7'h0F;
  localparam logic [6:0] OP_MAX  = 7'h12;
  localparam logic [6:0] OP_HALT = 7'h7F;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_COMMIT = 3'd6,
    S_STOP   = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic              taken_q, taken_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  function automatic logic is_branch(input logic [6:0] op);
    return (op >= OP_BRLO) && (op <= OP_MAX);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      taken_q   <= 1'b0;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      taken_q   <= taken_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    taken_d   = taken_q;
    cause_d   = cause_q;
    wait_d    = wait_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      // An ack arriving in the limit cycle takes priority over the timeout.
      S_FETCH: begin
        if (bus.imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_STOP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_HALT) begin
          state_d = S_STOP;
        end else if (opcode > OP_MAX) begin
          state_d = S_STOP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        taken_d = is_branch(op_q) ? pc_sel : 1'b0;
        if (is_branch(op_q)) begin
          state_d = S_COMMIT;
        end else if (is_mem(op_q)) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          state_d = (op_q == OP_SW) ? S_COMMIT : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_STOP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        instret_d = instret_q + 1'b1;
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_STOP;
      end
    endcase
  end

  // ir_en is the only output that looks at an input (the fetch ack).
  assign bus.imem_req = (state_q == S_FETCH);
  assign bus.ir_en    = (state_q == S_FETCH) && bus.imem_ack;
  assign bus.dmem_req = (state_q == S_MEM);
  assign bus.dmem_we  = (state_q == S_MEM) && (op_q == OP_SW);

  assign reg_wen    = (state_q == S_WB);
  assign pc_wen     = (state_q == S_COMMIT);
  assign pc_src     = (state_q == S_COMMIT) && taken_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_STOP);
  assign halted     = (state_q == S_STOP) && (cause_q == 2'b00);
  assign trap       = (state_q == S_STOP) && (cause_q != 2'b00);
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: instruction classes, ack delays,
// timeout boundary, illegal/halt stops and asynchronous reset.
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        pc_sel;
  logic        reg_wen, pc_wen, pc_src, busy, halted, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [2:0]  state;

  int n_vec = 0;
  int n_bad = 0;

  multicycle_seq_if bus ();

  multicycle_seq #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .pc_sel     (pc_sel),
    .bus        (bus),
    .reg_wen    (reg_wen),
    .pc_wen     (pc_wen),
    .pc_src     (pc_src),
    .busy       (busy),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0; opcode = 7'h00; pc_sel = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Runs one instruction from IDLE, answering acks after the given number of
  // un-acked request cycles, and tallies every strobe seen along the way.
  task automatic run_instr(input logic [6:0] op, input logic ps, input int idly,
                           input int ddly, input bit drop_run,
                           output int cyc, output int ireq, output int irp,
                           output int dreq, output int wep, output int regp,
                           output int pcp, output logic src);
    int iw, dw;
    cyc = 0; ireq = 0; irp = 0; dreq = 0; wep = 0; regp = 0; pcp = 0;
    src = 1'b0; iw = 0; dw = 0;
    opcode = op; pc_sel = ps; run = 1'b1;
    step();
    for (int k = 0; k < 64; k++) begin
      bus.imem_ack = (state == 3'd1) && (iw == idly);
      bus.dmem_ack = (state == 3'd4) && (dw == ddly);
      if (state == 3'd3 && drop_run) run = 1'b0;
      if (state == 3'd6) run = 1'b0;
      #1;
      if (state == 3'd0 || state == 3'd7) break;
      cyc++;
      if (bus.imem_req) begin ireq++; iw++; end
      if (bus.ir_en) irp++;
      if (bus.dmem_req) begin dreq++; dw++; if (bus.dmem_we) wep++; end
      if (reg_wen) regp++;
      if (pc_wen) begin pcp++; src = pc_src; end
      step();
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0; opcode = 7'h00; pc_sel = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    step(); step();
    n_vec++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_vec++; if ({bus.imem_req, bus.ir_en, bus.dmem_req, bus.dmem_we, reg_wen, pc_wen, pc_src} !== 7'b0)
      begin n_bad++; $display("FAIL reset_strobes got %b want 0", {bus.imem_req, bus.ir_en, bus.dmem_req, bus.dmem_we, reg_wen, pc_wen, pc_src}); end
    n_vec++; if ({busy, halted, trap, trap_cause} !== 5'b0) begin n_bad++; $display("FAIL reset_status got %b want 0", {busy, halted, trap, trap_cause}); end
    n_vec++; if (instret !== 32'd0) begin n_bad++; $display("FAIL reset_instret got %0d want 0", instret); end
    rst_n = 1'b1;
    step();
    n_vec++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_alu();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h03, 1'b0, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (cyc !== 5) begin n_bad++; $display("FAIL alu_cycles got %0d want 5", cyc); end
    n_vec++; if (irp !== 1) begin n_bad++; $display("FAIL alu_ir_en got %0d want 1", irp); end
    n_vec++; if (regp !== 1 || pcp !== 1) begin n_bad++; $display("FAIL alu_pulses got reg=%0d pc=%0d want 1/1", regp, pcp); end
    n_vec++; if (src !== 1'b0 || dreq !== 0) begin n_bad++; $display("FAIL alu_src_dreq got src=%0d dreq=%0d want 0/0", src, dreq); end
    n_vec++; if (instret !== 32'd1 || state !== 3'd0) begin n_bad++; $display("FAIL alu_end got instret=%0d state=%0d want 1/0", instret, state); end
  endtask

  task automatic test_lw();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h0D, 1'b0, 0, 3, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (cyc !== 9) begin n_bad++; $display("FAIL lw_cycles got %0d want 9", cyc); end
    n_vec++; if (dreq !== 4 || wep !== 0) begin n_bad++; $display("FAIL lw_dmem got req=%0d we=%0d want 4/0", dreq, wep); end
    n_vec++; if (regp !== 1) begin n_bad++; $display("FAIL lw_reg_wen got %0d want 1", regp); end
    n_vec++; if (instret !== 32'd2) begin n_bad++; $display("FAIL lw_instret got %0d want 2", instret); end
  endtask

  task automatic test_sw();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h0E, 1'b0, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (cyc !== 5) begin n_bad++; $display("FAIL sw_cycles got %0d want 5", cyc); end
    n_vec++; if (dreq !== 1 || wep !== 1) begin n_bad++; $display("FAIL sw_dmem got req=%0d we=%0d want 1/1", dreq, wep); end
    n_vec++; if (regp !== 0) begin n_bad++; $display("FAIL sw_reg_wen got %0d want 0", regp); end
    n_vec++; if (instret !== 32'd3) begin n_bad++; $display("FAIL sw_instret got %0d want 3", instret); end
  endtask

  task automatic test_branch();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h0F, 1'b1, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (cyc !== 4) begin n_bad++; $display("FAIL beq_t_cycles got %0d want 4", cyc); end
    n_vec++; if (src !== 1'b1 || pcp !== 1) begin n_bad++; $display("FAIL beq_t_pc got src=%0d pc=%0d want 1/1", src, pcp); end
    n_vec++; if (regp !== 0 || dreq !== 0) begin n_bad++; $display("FAIL beq_t_side got reg=%0d dreq=%0d want 0/0", regp, dreq); end
    run_instr(7'h0F, 1'b0, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (cyc !== 4 || src !== 1'b0) begin n_bad++; $display("FAIL beq_nt got cycles=%0d src=%0d want 4/0", cyc, src); end
    n_vec++; if (regp !== 0 || dreq !== 0) begin n_bad++; $display("FAIL beq_nt_side got reg=%0d dreq=%0d want 0/0", regp, dreq); end
    n_vec++; if (instret !== 32'd5) begin n_bad++; $display("FAIL beq_instret got %0d want 5", instret); end
  endtask

  task automatic test_run_drop();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h05, 1'b0, 0, 0, 1'b1, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (cyc !== 5 || pcp !== 1 || regp !== 1) begin n_bad++; $display("FAIL rundrop got cycles=%0d pc=%0d reg=%0d want 5/1/1", cyc, pcp, regp); end
    step();
    n_vec++; if (state !== 3'd0 || instret !== 32'd6) begin n_bad++; $display("FAIL rundrop_end got state=%0d instret=%0d want 0/6", state, instret); end
  endtask

  task automatic test_ack_at_limit();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h01, 1'b0, 15, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (ireq !== 16 || cyc !== 20) begin n_bad++; $display("FAIL acklimit got req=%0d cycles=%0d want 16/20", ireq, cyc); end
    n_vec++; if (trap !== 1'b0 || instret !== 32'd7) begin n_bad++; $display("FAIL acklimit_end got trap=%0d instret=%0d want 0/7", trap, instret); end
  endtask

  task automatic test_illegal();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    run_instr(7'h20, 1'b0, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (state !== 3'd7 || cyc !== 2) begin n_bad++; $display("FAIL illegal_stop got state=%0d cycles=%0d want 7/2", state, cyc); end
    n_vec++; if (trap !== 1'b1 || trap_cause !== 2'b01 || halted !== 1'b0) begin n_bad++; $display("FAIL illegal_flags got trap=%0d cause=%b halted=%0d want 1/01/0", trap, trap_cause, halted); end
    run = 1'b1; step(); step();
    n_vec++; if (state !== 3'd7 || busy !== 1'b0 || instret !== 32'd7) begin n_bad++; $display("FAIL illegal_absorb got state=%0d busy=%0d instret=%0d want 7/0/7", state, busy, instret); end
  endtask

  task automatic test_halt();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    do_reset();
    run_instr(7'h7F, 1'b0, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (halted !== 1'b1 || trap !== 1'b0 || trap_cause !== 2'b00) begin n_bad++; $display("FAIL halt_flags got halted=%0d trap=%0d cause=%b want 1/0/00", halted, trap, trap_cause); end
    n_vec++; if (instret !== 32'd0 || pcp !== 0) begin n_bad++; $display("FAIL halt_instret got instret=%0d pc=%0d want 0/0", instret, pcp); end
  endtask

  task automatic test_timeout();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    do_reset();
    run_instr(7'h03, 1'b0, 1000, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (ireq !== 16) begin n_bad++; $display("FAIL timeout_req_cycles got %0d want 16", ireq); end
    n_vec++; if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'b10) begin n_bad++; $display("FAIL timeout_flags got state=%0d trap=%0d cause=%b want 7/1/10", state, trap, trap_cause); end
    n_vec++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_req_drop got %0d want 0", bus.imem_req); end
  endtask

  task automatic test_reset_mid_mem();
    int cyc, ireq, irp, dreq, wep, regp, pcp; logic src;
    do_reset();
    run_instr(7'h02, 1'b0, 0, 0, 1'b0, cyc, ireq, irp, dreq, wep, regp, pcp, src);
    n_vec++; if (instret !== 32'd1) begin n_bad++; $display("FAIL pre_mem_instret got %0d want 1", instret); end
    opcode = 7'h0D; run = 1'b1; bus.imem_ack = 1'b1;
    for (int k = 0; k < 20 && state !== 3'd4; k++) step();
    bus.imem_ack = 1'b0;
    step(); step();
    n_vec++; if (bus.dmem_req !== 1'b1) begin n_bad++; $display("FAIL mid_mem_req got %0d want 1", bus.dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.dmem_req !== 1'b0 || state !== 3'd0 || instret !== 32'd0)
      begin n_bad++; $display("FAIL async_reset got req=%0d state=%0d instret=%0d want 0/0/0", bus.dmem_req, state, instret); end
    step();
    rst_n = 1'b1; run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_branch();
    test_run_drop();
    test_ack_at_limit();
    test_illegal();
    test_halt();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
